instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the ARM single-cycle datapath. Sits between the instruction memory and the datapath.
- Owns the program counter and drives the instruction-memory address.
- Captures each returned instruction word, paired with its PC, into a small prefetch FIFO.
- Presents the FIFO head to the datapath over a valid/ready handshake. Handles redirects (branches) by flushing the FIFO and reloading the PC.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width in bits
- INSTR_W, 32, instruction word width in bits
- DEPTH, 2, prefetch FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- imem_addr  out  ADDR_W  instruction-memory address; equals the PC register
- imem_rdata  in  INSTR_W  instruction word at imem_addr; combinational read, valid in the same cycle
- out_valid  out  1  FIFO head holds a valid instruction
- out_ready  in  1  datapath accepts the head this cycle
- out_instr  out  INSTR_W  instruction word at the FIFO head
- out_pc  out  ADDR_W  address of out_instr
- redirect_valid  in  1  branch taken; redirect fetch this cycle
- redirect_target  in  ADDR_W  new fetch address
- fetch_count  out  $clog2(DEPTH+1)  current FIFO occupancy, for debug and the verification scoreboard

Behaviour:
- Reset (rst=0, asynchronous):
  - pc <= RESET_PC; count, read pointer and write pointer <= 0.
  - Outputs: out_valid=0, fetch_count=0, imem_addr=RESET_PC. out_instr and out_pc are don't-care while out_valid=0; the bench must not check them.
  - Asserting reset mid-operation discards all buffered entries immediately, with no clock required.
- Handshake:
  - pop = out_valid & out_ready.
  - out_valid = (count != 0). It never depends combinationally on out_ready.
- Fetch/push:
  - push = !redirect_valid & (count < DEPTH | pop).
  - On push, the FIFO stores {pc, imem_rdata} at the write pointer and pc <= pc + 4.
  - When full and not popping, pc holds and no entry is written.
- PC arithmetic:
  - Unsigned, modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 wraps to 0.
  - pc[1:0] is always 0; redirect_target[1:0] is ignored (forced to 0 on load).
- Latency:
  - First edge after reset release pushes the instruction at RESET_PC; out_valid rises after that edge.
  - Steady state with out_ready=1: one instruction per cycle, out_pc advancing by 4.
- Redirect (highest priority):
  - When redirect_valid=1 at an edge: count and both pointers <= 0, pc <= {redirect_target[ADDR_W-1:2], 2'b00}, no push that cycle.
  - The next cycle has out_valid=0 and imem_addr=target.
  - The first target instruction becomes valid one edge later. Redirect-to-valid latency is 2 edges.
- Redirect with a simultaneous pop: the consumer's acceptance of the current head stands; everything else is flushed.
- Back-to-back redirects: the latest target wins; out_valid stays 0 until one cycle after the last redirect.
- Full with pop in the same cycle: push and pop both occur; count is unchanged and pointers advance mod DEPTH.
- Empty: the head fields are don't-care; pop is impossible because out_valid=0.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH. fetch_count = count.

Decomposition:
- Shared package (arm_fetch_pkg) holds:
  - ADDR_W and INSTR_W defaults
  - the PC_INCR constant (4)
  - the fetch-entry struct {pc, instr}
- One sub-module: fetch_fifo, a generic synchronous FIFO with push, pop, flush, count and head outputs, parameterised by DEPTH and entry width.
- PC register, push/redirect logic and imem_addr drive live in instr_fetch_unit.

Test Plan:
- Reset then stream: RESET_PC=0, IM word at address a = 32'hE000_0000 | a, out_ready=1 → out_valid rises after edge 1; out_pc sequence 0,4,8,12 with matching out_instr, one per cycle.
- Backpressure: out_ready=0 for 5 cycles after reset → fetch_count reaches 2, imem_addr holds at 8. Then out_ready=1 → out_pc 0,4,8 delivered with no gaps or duplicates.
- Redirect: redirect_valid=1 with target 32'h0000_0103 while head pc=4 and out_ready=1 → head 4 consumed. Next cycle out_valid=0 and imem_addr=32'h100; following cycle out_pc=32'h100.
- Wrap: redirect to 32'hFFFF_FFF8, out_ready=1 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stream: rst=0 pulsed between edges while count=2 → out_valid=0 and fetch_count=0 immediately; after release the stream restarts at RESET_PC.
- Back-to-back redirects: redirects to 32'h40 then 32'h80 on consecutive cycles → no pc 32'h40 is ever delivered; first valid out_pc is 32'h80.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// Shared definitions for the ARM fetch front end: default widths, PC step
// and the layout of one prefetch entry.
package arm_fetch_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int INSTR_W_DEF = 32;
   localparam int PC_INCR     = 4;

   // Entry layout at default widths; the FIFO stores {pc, instr} in this order.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0]  pc;
      logic [INSTR_W_DEF-1:0] instr;
   } fetch_entry_t;

   localparam int ENTRY_W_DEF = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head is presented combinationally
// from the read pointer. DEPTH must be a power of two, at least 2.
module fetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = arm_fetch_pkg::ENTRY_W_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // Flush wins over everything; a pop coinciding with a flush is simply absorbed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives imem_addr, buffers
// {pc, instr} pairs in a prefetch FIFO and hands them to the datapath.
module instr_fetch_unit
   import arm_fetch_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]         imem_rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INSTR_W-1:0]         out_instr,
   output logic [ADDR_W-1:0]          out_pc,
   input  logic                       redirect_valid,
   input  logic [ADDR_W-1:0]          redirect_target,
   output logic [$clog2(DEPTH+1)-1:0] fetch_count
);

   localparam int ENTRY_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0]  pc;
   logic [ENTRY_W-1:0] head;
   logic               fifo_empty;
   logic               fifo_full;
   logic               push;
   logic               pop;
   logic               unused_target_lsbs;

   // Handshake: out_valid depends only on occupancy; a transfer happens on an
   // edge where out_valid & out_ready, and the head then advances.
   assign out_valid = !fifo_empty;
   assign pop       = out_valid & out_ready;
   assign push      = !redirect_valid & (!fifo_full | pop);

   assign imem_addr = pc;
   assign out_pc    = head[INSTR_W +: ADDR_W];
   assign out_instr = head[INSTR_W-1:0];

   // Targets are word aligned; the two low bits are dropped on load.
   assign unused_target_lsbs = ^redirect_target[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= {redirect_target[ADDR_W-1:2], 2'b00};
      end else if (push) begin
         pc <= pc + ADDR_W'(PC_INCR);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ({pc, imem_rdata}),
      .dout  (head),
      .count (fetch_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational instruction memory
// whose word at address a is 32'hE000_0000 | a.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [1:0]  fetch_count;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .DEPTH    (2),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .fetch_count     (fetch_count)
   );

   assign imem_rdata = 32'hE000_0000 | imem_addr;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Hold reset across one falling edge, check the reset state, release.
   task automatic do_reset(input logic ready);
      rst = 1'b0;
      out_ready = ready;
      redirect_valid = 1'b0;
      redirect_target = '0;
      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_count", {30'b0, fetch_count}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = '0;

      // Reset then stream
      do_reset(1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stream_valid", {31'b0, out_valid}, 32'd1);
         chk("stream_pc", out_pc, 32'(4 * i));
         chk("stream_instr", out_instr, 32'hE000_0000 | 32'(4 * i));
      end

      // Backpressure
      do_reset(1'b0);
      repeat (5) @(negedge clk);
      chk("bp_count", {30'b0, fetch_count}, 32'd2);
      chk("bp_addr", imem_addr, 32'h8);
      chk("bp_pc0", out_pc, 32'h0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_pc1", out_pc, 32'h4);
      chk("bp_count1", {30'b0, fetch_count}, 32'd2);
      @(negedge clk);
      chk("bp_pc2", out_pc, 32'h8);
      chk("bp_instr2", out_instr, 32'hE000_0008);

      // Redirect while head pc=4 is being accepted
      do_reset(1'b1);
      @(negedge clk);
      chk("rd_pc0", out_pc, 32'h0);
      @(negedge clk);
      chk("rd_pc4", out_pc, 32'h4);
      redirect_valid = 1'b1;
      redirect_target = 32'h0000_0103;
      @(negedge clk);
      chk("rd_valid", {31'b0, out_valid}, 32'd0);
      chk("rd_addr", imem_addr, 32'h100);
      chk("rd_count", {30'b0, fetch_count}, 32'd0);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("rd_valid2", {31'b0, out_valid}, 32'd1);
      chk("rd_tpc", out_pc, 32'h100);
      chk("rd_tinstr", out_instr, 32'hE000_0100);

      // Wrap through the top of the address space
      redirect_valid = 1'b1;
      redirect_target = 32'hFFFF_FFF8;
      @(negedge clk);
      chk("wr_valid", {31'b0, out_valid}, 32'd0);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("wr_pc0", out_pc, 32'hFFFF_FFF8);
      chk("wr_instr0", out_instr, 32'hFFFF_FFF8);
      @(negedge clk);
      chk("wr_pc1", out_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wr_pc2", out_pc, 32'h0000_0000);
      chk("wr_instr2", out_instr, 32'hE000_0000);

      // Asynchronous reset mid-stream with a full FIFO
      do_reset(1'b0);
      repeat (2) @(negedge clk);
      chk("ar_count_pre", {30'b0, fetch_count}, 32'd2);
      #1 rst = 1'b0;
      #1;
      chk("ar_valid", {31'b0, out_valid}, 32'd0);
      chk("ar_count", {30'b0, fetch_count}, 32'd0);
      chk("ar_addr", imem_addr, 32'h0);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("ar_restart_pc", out_pc, 32'h0);
      chk("ar_restart_count", {30'b0, fetch_count}, 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("ar_next_pc", out_pc, 32'h4);

      // Back-to-back redirects: the later target wins
      redirect_valid = 1'b1;
      redirect_target = 32'h40;
      @(negedge clk);
      chk("bb_valid1", {31'b0, out_valid}, 32'd0);
      chk("bb_addr1", imem_addr, 32'h40);
      redirect_target = 32'h80;
      @(negedge clk);
      chk("bb_valid2", {31'b0, out_valid}, 32'd0);
      chk("bb_addr2", imem_addr, 32'h80);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("bb_valid3", {31'b0, out_valid}, 32'd1);
      chk("bb_pc", out_pc, 32'h80);
      @(negedge clk);
      chk("bb_pc_next", out_pc, 32'h84);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
